membrane_integrator: RTL and testbench

Per-neuron leaky integrate-and-fire stage that sits directly downstream of the neuron's adder/subtractor datapath. Once per timestep it accumulates a stream of signed synaptic weights into a saturating membrane potential. It then applies leak toward a resting level, compares the result against a threshold, and emits a one-cycle spike. A refractory counter suppresses integration after each spike. Its outputs feed the neuron's spike packetiser in the NoC router interface.

---
 rtl/membrane_integrator_if.sv | 8 +
 rtl/membrane_integrator.sv | 99 +++++++++
 tb/tb_membrane_integrator.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/membrane_integrator_if.sv
// membrane_integrator_if: synaptic weight valid/ready stream into the integrator
interface membrane_integrator_if #(parameter int DSIZE = 16) ();
    logic                    syn_valid_i;
    logic signed [DSIZE-1:0] syn_weight_i;
    logic                    syn_ready_o;
    modport master (output syn_valid_i, syn_weight_i, input syn_ready_o);
    modport slave (input syn_valid_i, syn_weight_i, output syn_ready_o);
endinterface

// File: rtl/membrane_integrator.sv
// membrane_integrator: leaky integrate-and-fire membrane with saturation and refractory period
module membrane_integrator #(
    parameter int DSIZE = 16,
    parameter int RSIZE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    step_i,
    input  logic                    step_done_i,
    membrane_integrator_if.slave    syn,
    input  logic        [DSIZE-1:0] leak_i,
    input  logic signed [DSIZE-1:0] threshold_i,
    input  logic signed [DSIZE-1:0] rest_i,
    input  logic        [RSIZE-1:0] refrac_i,
    output logic signed [DSIZE-1:0] vmem_o,
    output logic                    spike_o,
    output logic                    done_o,
    output logic                    sat_o,
    output logic                    busy_o
);
    typedef enum logic [1:0] {IDLE, ACCUM, LEAK, FIRE} state_t;
    localparam logic signed [DSIZE+1:0] VMAX = {3'b000, {(DSIZE-1){1'b1}}};
    localparam logic signed [DSIZE+1:0] VMIN = {3'b111, {(DSIZE-1){1'b0}}};
    state_t state, state_n;
    logic signed [DSIZE-1:0] vmem_n;
    logic [RSIZE-1:0] cnt, cnt_n;
    logic spike_n, done_n, sat_n;
    logic signed [DSIZE+1:0] v, w, r, l, sum, dn, up;
    // two guard bits keep vmem +/- an unsigned leak from wrapping before the clamp
    assign v = {{2{vmem_o[DSIZE-1]}}, vmem_o};
    assign w = {{2{syn.syn_weight_i[DSIZE-1]}}, syn.syn_weight_i};
    assign r = {{2{rest_i[DSIZE-1]}}, rest_i};
    assign l = {2'b00, leak_i};
    assign sum = v + w;
    assign dn = v - l;
    assign up = v + l;
    assign syn.syn_ready_o = state == ACCUM;
    assign busy_o = state != IDLE;
    // next-state and next-datapath values; refractory weights are consumed but discarded
    always_comb begin
        state_n = state;
        vmem_n = vmem_o;
        cnt_n = cnt;
        spike_n = 1'b0;
        done_n = 1'b0;
        sat_n = sat_o;
        case (state)
            IDLE: begin
                if (step_i) begin
                    state_n = ACCUM;
                    sat_n = 1'b0;
                end
            end
            ACCUM: begin
                if (syn.syn_valid_i && !(|cnt)) begin
                    vmem_n = sum > VMAX ? VMAX[DSIZE-1:0] : sum < VMIN ? VMIN[DSIZE-1:0] : sum[DSIZE-1:0];
                    sat_n = sat_o | (sum > VMAX) | (sum < VMIN);
                end
                if (step_done_i) state_n = LEAK;
            end
            LEAK: begin
                vmem_n = v > r ? (dn < r ? rest_i : dn[DSIZE-1:0]) :
                         v < r ? (up > r ? rest_i : up[DSIZE-1:0]) : vmem_o;
                state_n = FIRE;
            end
            FIRE: begin
                state_n = IDLE;
                done_n = 1'b1;
                if (|cnt) begin
                    cnt_n = cnt - 1'b1;
                    vmem_n = rest_i;
                end else if (vmem_o >= threshold_i) begin
                    spike_n = 1'b1;
                    vmem_n = rest_i;
                    cnt_n = refrac_i;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state and registered outputs; reset abandons any partial accumulation
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            vmem_o <= '0;
            cnt <= '0;
            spike_o <= 1'b0;
            done_o <= 1'b0;
            sat_o <= 1'b0;
        end else begin
            state <= state_n;
            vmem_o <= vmem_n;
            cnt <= cnt_n;
            spike_o <= spike_n;
            done_o <= done_n;
            sat_o <= sat_n;
        end
    end
endmodule

// File: tb/tb_membrane_integrator.sv
// tb_membrane_integrator: directed steps with a scoreboard of expected step results
module tb_membrane_integrator;
    logic clk = 0, rst_n = 0, step = 0, step_done = 0;
    logic [15:0] leak = 0;
    logic signed [15:0] thr = 0, rest = 0;
    logic [3:0] refrac = 0;
    logic signed [15:0] vmem;
    logic spike, done, sat, busy;
    int total = 0, bad = 0;
    typedef struct {logic signed [15:0] pre, v; logic spk, sat;} exp_t;
    exp_t sbq[$];
    logic signed [15:0] wq[$];
    membrane_integrator_if #(16) syn();
    membrane_integrator #(.DSIZE(16), .RSIZE(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .step_i(step), .step_done_i(step_done), .syn(syn),
        .leak_i(leak), .threshold_i(thr), .rest_i(rest), .refrac_i(refrac),
        .vmem_o(vmem), .spike_o(spike), .done_o(done), .sat_o(sat), .busy_o(busy));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] o, input logic signed [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full timestep using the weights in wq; merge puts step_done on the last weight
    task automatic run_step(input logic merge, input logic poke, input logic signed [15:0] pre,
                            input logic signed [15:0] v, input logic spk, input logic s);
        exp_t e, got;
        logic signed [15:0] pre_obs;
        int n;
        e.pre = pre; e.v = v; e.spk = spk; e.sat = s;
        sbq.push_back(e);
        n = wq.size();
        tick();
        step = 1;
        tick();
        step = 0;
        chk("ready_T1", syn.syn_ready_o, 1);
        chk("busy_T1", busy, 1);
        chk("sat_clr", sat, 0);
        for (int i = 0; i < n; i++) begin
            syn.syn_valid_i = 1;
            syn.syn_weight_i = wq[i];
            step_done = merge && i == n - 1;
            step = poke && i == 0;
            tick();
        end
        step = 0;
        syn.syn_valid_i = 0;
        if (!(merge && n > 0)) begin
            step_done = 1;
            tick();
        end
        step_done = 0;
        wq.delete();
        chk("done_U1", done, 0);
        tick();
        pre_obs = vmem;
        chk("done_U2", done, 0);
        tick();
        chk("done_U3", done, 1);
        if (done === 1'b1 && sbq.size() > 0) begin
            got = sbq.pop_front();
            chk("vmem_pre_fire", pre_obs, got.pre);
            chk("vmem", vmem, got.v);
            chk("spike", spike, got.spk);
            chk("sat", sat, got.sat);
        end
        chk("busy_U3", busy, 0);
        tick();
        chk("done_pulse", done, 0);
        chk("spike_pulse", spike, 0);
    endtask

    initial begin
        syn.syn_valid_i = 0;
        syn.syn_weight_i = 0;
        #12;
        chk("rst_vmem", vmem, 0);
        chk("rst_spike", spike, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", syn.syn_ready_o, 0);
        @(negedge clk);
        rst_n = 1;
        leak = 2; thr = 100; rest = 0; refrac = 3;
        wq = '{16'sd50, 16'sd60};
        run_step(0, 0, 108, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            wq = '{16'sd200};
            run_step(0, 0, 0, 0, 0, 0);
        end
        refrac = 0;
        wq = '{16'sd200};
        run_step(0, 0, 198, 0, 1, 0);
        leak = 0; thr = 32767;
        wq = '{16'sd16000, 16'sd16000};
        run_step(0, 0, 32000, 32000, 0, 0);
        wq = '{16'sd1000};
        run_step(0, 0, 32767, 0, 1, 1);
        leak = 2; thr = 100;
        wq = '{-16'sd5};
        run_step(0, 0, -3, -3, 0, 0);
        leak = 10;
        wq = '{16'sd7};
        run_step(0, 0, 0, 0, 0, 0);
        leak = 0;
        wq = '{16'sd30};
        run_step(1, 0, 30, 30, 0, 0);
        wq = '{16'sd10};
        run_step(0, 1, 40, 40, 0, 0);
        syn.syn_valid_i = 1;
        syn.syn_weight_i = 100;
        step_done = 1;
        tick();
        chk("idle_ready", syn.syn_ready_o, 0);
        tick();
        syn.syn_valid_i = 0;
        step_done = 0;
        chk("idle_busy", busy, 0);
        chk("idle_vmem", vmem, 40);
        tick();
        tick();
        chk("idle_done", done, 0);
        thr = 30; refrac = 5;
        run_step(1, 0, 40, 0, 1, 0);
        tick();
        step = 1;
        tick();
        step = 0;
        syn.syn_valid_i = 1;
        syn.syn_weight_i = 9;
        tick();
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_vmem", vmem, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", syn.syn_ready_o, 0);
        chk("arst_done", done, 0);
        chk("arst_spike", spike, 0);
        chk("arst_sat", sat, 0);
        syn.syn_valid_i = 0;
        @(negedge clk);
        rst_n = 1;
        thr = 100; refrac = 0;
        wq = '{16'sd20};
        run_step(0, 0, 20, 20, 0, 0);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
